// File: rtl/pilha_parametrizada.sv
// Parametrised LIFO stack with registered top-of-stack, occupancy count and sticky error flags.
// Optional almost_full output is enabled by defining PILHA_ALMOST_FULL_EN.
module pilha_parametrizada #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 10,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_err_i,
    input  logic [WIDTH-1:0]           data_in_i,
    output logic [WIDTH-1:0]           data_out_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o
`ifdef PILHA_ALMOST_FULL_EN
    ,
    output logic                       almost_full_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ovf_set, udf_set;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx, next_idx, below_idx;
    logic             full, empty;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // Index wrap on the out-of-range cases is harmless: those paths never use them.
    assign top_idx   = AW'(count_q - CW'(1));
    assign next_idx  = AW'(count_q);
    assign below_idx = AW'(count_q - CW'(2));

    always_comb begin
        count_d    = count_q;
        data_out_d = data_out_q;
        wr_en      = 1'b0;
        wr_idx     = top_idx;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;

        if (push_i && pop_i) begin
            wr_en      = 1'b1;
            data_out_d = data_in_i;
            if (empty) begin
                wr_idx  = '0;
                count_d = CW'(1);
                udf_set = 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (push_i) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en      = 1'b1;
                wr_idx     = next_idx;
                count_d    = count_q + CW'(1);
                data_out_d = data_in_i;
            end
        end else if (pop_i) begin
            if (empty) begin
                udf_set = 1'b1;
            end else begin
                count_d    = count_q - CW'(1);
                data_out_d = (count_q == CW'(1)) ? '0 : mem_q[below_idx];
            end
        end

        // Set wins over a simultaneous clear.
        overflow_d  = (overflow_q & ~clear_err_i) | ovf_set;
        underflow_d = (underflow_q & ~clear_err_i) | udf_set;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_in_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out_o  = data_out_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

`ifdef PILHA_ALMOST_FULL_EN
    localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);

    logic almost_full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= AF_CNT);
        end
    end

    assign almost_full_o = almost_full_q;
`else
    logic unused_af_level;
    assign unused_af_level = ^AF_LEVEL;
`endif

endmodule

// File: tb/tb_pilha_parametrizada.sv
// Directed bench for pilha_parametrizada (WIDTH=4, DEPTH=4) with a queue-based scoreboard.
module tb_pilha_parametrizada;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             udf;
`ifdef PILHA_ALMOST_FULL_EN
    logic             af;
`endif

    pilha_parametrizada #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(3)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_i       (push),
        .pop_i        (pop),
        .clear_err_i  (clr),
        .data_in_i    (din),
        .data_out_o   (dout),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty),
        .overflow_o   (ovf),
        .underflow_o  (udf)
`ifdef PILHA_ALMOST_FULL_EN
        ,
        .almost_full_o(af)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] dout;
        logic             full;
        logic             empty;
        logic             ovf;
        logic             udf;
        logic             af;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] stk[$];
    logic             m_ovf;
    logic             m_udf;
    int               n_cmp;
    int               n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enqueue();
        exp_t e;
        e.count = CW'(stk.size());
        e.dout  = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        e.full  = (stk.size() == DEPTH);
        e.empty = (stk.size() == 0);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.af    = (stk.size() >= 3);
        sb.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: observed empty scoreboard required one entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".count"}, 32'(count), 32'(e.count));
        check({tag, ".data_out"}, 32'(dout), 32'(e.dout));
        check({tag, ".full"}, 32'(full), 32'(e.full));
        check({tag, ".empty"}, 32'(empty), 32'(e.empty));
        check({tag, ".overflow"}, 32'(ovf), 32'(e.ovf));
        check({tag, ".underflow"}, 32'(udf), 32'(e.udf));
`ifdef PILHA_ALMOST_FULL_EN
        check({tag, ".almost_full"}, 32'(af), 32'(e.af));
`endif
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Reference behaviour of one clock edge, written against a queue-as-stack.
    task automatic step(input string tag, input logic p, input logic q, input logic c,
                        input logic [WIDTH-1:0] d);
        logic os, us;
        @(negedge clk);
        push = p;
        pop  = q;
        clr  = c;
        din  = d;
        os   = 1'b0;
        us   = 1'b0;
        if (p && q) begin
            if (stk.size() > 0) begin
                stk[stk.size()-1] = d;
            end else begin
                stk.push_back(d);
                us = 1'b1;
            end
        end else if (p) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else os = 1'b1;
        end else if (q) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else us = 1'b1;
        end
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        m_ovf = m_ovf | os;
        m_udf = m_udf | us;
        enqueue();
        @(posedge clk);
        #1;
        sample(tag);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        clr    = 1'b0;
        din    = '0;
        model_reset();
        #3;
        enqueue();
        sample("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Push sequence up to full.
        step("push1", 1, 0, 0, 4'b1010);
        step("push2", 1, 0, 0, 4'b1111);
        step("push3", 1, 0, 0, 4'b0001);
        step("push4", 1, 0, 0, 4'b1010);

        // Overflow, clear, set-wins-over-clear, replace while full.
        step("ovf", 1, 0, 0, 4'b0110);
        step("ovf_hold", 0, 0, 0, 4'b0000);
        step("clr_ovf", 0, 0, 1, 4'b0000);
        step("ovf_setwin", 1, 0, 1, 4'b0111);
        step("clr_ovf2", 0, 0, 1, 4'b0000);
        step("repl_full", 1, 1, 0, 4'b0101);

        // Pop then push.
        step("pop1", 0, 1, 0, 4'b0000);
        step("pop2", 0, 1, 0, 4'b0000);
        step("push_c", 1, 0, 0, 4'b1100);

        // Drain to empty, underflow, replace.
        step("drain1", 0, 1, 0, 4'b0000);
        step("drain2", 0, 1, 0, 4'b0000);
        step("drain3", 0, 1, 0, 4'b0000);
        step("udf", 0, 1, 0, 4'b0000);
        step("clr_udf", 0, 0, 1, 4'b0000);
        step("push_3", 1, 0, 0, 4'b0011);
        step("repl", 1, 1, 0, 4'b0101);
        step("pop_last", 0, 1, 0, 4'b0000);
        step("pushpop_empty", 1, 1, 0, 4'b0111);
        step("clr_udf2", 0, 0, 1, 4'b0000);

        // Async reset mid-cycle with count=3.
        step("pre_rst1", 1, 0, 0, 4'b1000);
        step("pre_rst2", 1, 0, 0, 4'b0100);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        enqueue();
        sample("async_rst");
        push = 1'b1;
        din  = 4'b1110;
        @(posedge clk);
        #1;
        enqueue();
        sample("rst_held");
        @(negedge clk);
        push  = 1'b0;
        rst_n = 1'b1;
        step("post_rst", 1, 0, 0, 4'b1001);

`ifdef PILHA_ALMOST_FULL_EN
        step("af_push2", 1, 0, 0, 4'b0010);
        step("af_push3", 1, 0, 0, 4'b0011);
        step("af_pop", 0, 1, 0, 4'b0000);
`endif
        step("idle", 0, 0, 0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pilha_parametrizada.md
# pilha_parametrizada

Parametrised LIFO stack, the successor to the 4-bit/10-entry instruction stack. It serves the processor's instruction and return-address path and adds the following:
- configurable width and depth;
- an occupancy count;
- registered top-of-stack;
- push+pop replace-top in a single cycle;
- sticky overflow/underflow error flags.

It sits between the control unit (push/pop commands) and the fetch/branch logic (consumes `data_out`).

## Interface
- `WIDTH`, 4: data word width in bits (≥1).
- `DEPTH`, 10: number of entries (≥2).
- `AF_LEVEL`, DEPTH-1: almost-full threshold. Used only when `PILHA_ALMOST_FULL_EN` is defined.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset. `reset`=0 clears all state immediately.
- `push` in 1: write `data_in` onto the stack at the next rising edge.
- `pop` in 1: remove the top entry at the next rising edge.
- `clear_err` in 1: synchronous clear of `overflow`/`underflow`.
- `data_in` in WIDTH: word to push.
- `data_out` out WIDTH: registered top-of-stack. 0 when empty.
- `count` out $clog2(DEPTH+1): current occupancy, 0..DEPTH.
- `full` out 1: `count`==DEPTH.
- `empty` out 1: `count`==0.
- `overflow` out 1: sticky. Set by a push-only command while full.
- `underflow` out 1: sticky. Set by a pop while empty.
- `almost_full` out 1: present only with `PILHA_ALMOST_FULL_EN`.

## Operation
- Storage: DEPTH×WIDTH register array plus stack pointer `sp` (= `count`). The top entry is `mem[sp-1]`.
- Per-edge command decode, priority as listed:
  - push=1, pop=1, non-empty: replace top. `mem[sp-1]`←`data_in`, `count` unchanged, no error. Also legal when full.
  - push=1, pop=1, empty: perform push only, `count`→1. Set `underflow`.
  - push=1, pop=0, not full: `mem[sp]`←`data_in`, `count`+1.
  - push=1, pop=0, full: no write, `count` unchanged, set `overflow`. Contents preserved.
  - push=0, pop=1, non-empty: `count`−1. The popped entry is not cleared.
  - push=0, pop=1, empty: no change, set `underflow`.
  - neither: hold.
- `data_out` is registered. After every edge it equals the new top (`mem[count-1]`), or 0 when the new `count` is 0. On a push it takes `data_in` directly, with no memory read-after-write hazard.
- `full` and `empty` are decoded from the registered `count`.
- `clear_err`=1 clears both error flags at the edge. If an error event occurs in the same cycle, the flag is set (set wins).
- `count` never wraps: no increment at DEPTH, no decrement at 0.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - `count`=0, `data_out`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `almost_full`=0.
  - Memory contents are don't-care.
- Latency: a command sampled at edge N is reflected on every output immediately after edge N (1-cycle latency, no bubbles). Back-to-back push/pop is allowed every cycle.
- Reset mid-operation: outputs return to reset values without waiting for a clock edge. The first command after `reset` rises is honoured at the next edge.
- Commands are level-sampled. Holding `push` high for k cycles performs k pushes.

## Configuration
- Macro `PILHA_ALMOST_FULL_EN`.
  - Defined: the `almost_full` output exists and equals (`count` ≥ `AF_LEVEL`). It is registered with the same timing as `full`.
  - Not defined: the `almost_full` port and its logic are compiled out. `AF_LEVEL` is ignored. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, DEPTH=4.
1. Push sequence: reset, then push 1010, 1111, 0001, 1010 (one per cycle).
   - `count` steps 1..4.
   - `data_out` 1010, 1111, 0001, 1010.
   - `full`=1 after the 4th push, `overflow`=0.
2. Pop then push: from state 1, pop, pop, push 1100.
   - `data_out` 0001 → 1111 → 1100.
   - `count` 3 → 2 → 3.
3. Overflow: when full, push 0110.
   - `overflow`=1, `count`=4, `data_out` unchanged (1010).
   - Then `clear_err` → `overflow`=0.
4. Underflow and replace:
   - When empty, pop → `underflow`=1, `count`=0, `data_out`=0.
   - Push 0011, then push+pop with 0101 → `count`=1, `data_out`=0101.
5. Async reset: assert `reset`=0 mid-cycle with `count`=3.
   - Outputs go to reset values before the next edge.
   - After release, push 1001 → `count`=1, `data_out`=1001.
6. Almost-full: with `PILHA_ALMOST_FULL_EN` and AF_LEVEL=3, push three words.
   - `almost_full` rises after the 3rd push and falls after the next pop.
